// File: rtl/sw_target_feeder_mc_if.sv
// Record-in / per-channel-base-out bundle for the Smith-Waterman target feeder.
// master = record source and result collector side, slave = feeder side.
interface sw_target_feeder_mc_if #(
   parameter int TARGET_LENGTH = 128,
   parameter int LEN_WIDTH     = 12,
   parameter int ID_WIDTH      = 48,
   parameter int CHANNELS      = 4
);
   localparam int IN_WIDTH = ID_WIDTH + LEN_WIDTH + 2 * TARGET_LENGTH;

   logic [IN_WIDTH-1:0]          in_data;
   logic                         in_valid;
   logic                         in_ready;
   logic [CHANNELS-1:0]          en;
   logic [CHANNELS-1:0]          last;
   logic [2*CHANNELS-1:0]        data_out;
   logic [CHANNELS-1:0]          id_re;
   logic [ID_WIDTH*CHANNELS-1:0] id_out;
   logic [CHANNELS-1:0]          id_empty;
   logic                         len_err;

   modport master (
      output in_data, in_valid, id_re,
      input  in_ready, en, last, data_out, id_out, id_empty, len_err
   );

   modport slave (
      input  in_data, in_valid, id_re,
      output in_ready, en, last, data_out, id_out, id_empty, len_err
   );
endinterface

// File: rtl/sw_target_feeder_mc.sv
// N-channel round-robin target feeder: shifts one 2-bit base per cycle to each busy channel
// and queues record IDs per channel. Optional per-channel stall under SW_FEEDER_STALL_EN.
module sw_target_feeder_mc #(
   parameter int TARGET_LENGTH = 128,
   parameter int LEN_WIDTH     = 12,
   parameter int ID_WIDTH      = 48,
   parameter int CHANNELS      = 4,
   parameter int ID_FIFO_DEPTH = 4
) (
   input logic clk,
   input logic rst,
`ifdef SW_FEEDER_STALL_EN
   input logic [CHANNELS-1:0] stall,
`endif
   sw_target_feeder_mc_if.slave bus
);
   localparam int IN_WIDTH = ID_WIDTH + LEN_WIDTH + 2 * TARGET_LENGTH;
   localparam int TW       = 2 * TARGET_LENGTH;
   localparam int PW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int AW       = (ID_FIFO_DEPTH > 1) ? $clog2(ID_FIFO_DEPTH) : 1;
   localparam int CW       = $clog2(ID_FIFO_DEPTH + 1);

   typedef enum logic {IDLE, FEED} state_t;

   function automatic logic len_ok(input logic [LEN_WIDTH-1:0] l);
      return (l != '0) && (l <= LEN_WIDTH'(TARGET_LENGTH));
   endfunction

   function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] p);
      return (p == PW'(CHANNELS - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(ID_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   logic [TW-1:0]        rec_target;
   logic [LEN_WIDTH-1:0] rec_len;
   logic [ID_WIDTH-1:0]  rec_id;
   logic                 rec_ok;
   logic                 accept;
   logic [CHANNELS-1:0]  avail;
   logic [CHANNELS-1:0]  load;
   logic [CHANNELS-1:0]  hold;
   logic [PW-1:0]        rr;
   logic [PW-1:0]        sel;
   logic                 len_err_r;

   assign rec_target = bus.in_data[TW-1:0];
   assign rec_len    = bus.in_data[TW +: LEN_WIDTH];
   assign rec_id     = bus.in_data[IN_WIDTH-1 -: ID_WIDTH];
   assign rec_ok     = len_ok(rec_len);

`ifdef SW_FEEDER_STALL_EN
   assign hold = stall;
`else
   assign hold = '0;
`endif

   assign bus.in_ready = |avail;
   assign accept       = bus.in_valid & bus.in_ready;
   assign bus.len_err  = len_err_r;

   // Pick the available channel with the smallest forward distance from the RR pointer.
   always_comb begin
      int best;
      int d;
      best = CHANNELS;
      d    = 0;
      sel  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         d = c - int'(rr);
         if (d < 0) d = d + CHANNELS;
         if (avail[c] && (d < best)) begin
            best = d;
            sel  = PW'(c);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rr        <= '0;
         len_err_r <= 1'b0;
      end else begin
         len_err_r <= accept & ~rec_ok;
         if (accept && rec_ok) rr <= rr_next(sel);
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      state_t               state;
      logic                 last_r;
      logic [TW-1:0]        sreg;
      logic [LEN_WIDTH-1:0] cnt;
      logic [LEN_WIDTH-1:0] len_m1;
      logic [ID_WIDTH-1:0]  mem [ID_FIFO_DEPTH];
      logic [AW-1:0]        wptr;
      logic [AW-1:0]        rptr;
      logic [CW-1:0]        count;
      logic                 step;
      logic                 full;
      logic                 pop;

      assign step     = (state == FEED) && !hold[c];
      assign full     = (count == CW'(ID_FIFO_DEPTH));
      // A channel on its final base can take the next record without a bubble.
      assign avail[c] = ((state == IDLE) || (last_r && !hold[c])) && !full;
      assign load[c]  = accept && rec_ok && (sel == PW'(c));
      assign pop      = bus.id_re[c] && (count != '0);

      always_ff @(posedge clk) begin
         if (!rst) begin
            state  <= IDLE;
            last_r <= 1'b0;
         end else if (load[c]) begin
            state  <= FEED;
            last_r <= (rec_len == LEN_WIDTH'(1));
         end else if (step) begin
            if (last_r) begin
               state  <= IDLE;
               last_r <= 1'b0;
            end else begin
               last_r <= ((cnt + 1'b1) == len_m1);
            end
         end
      end

      always_ff @(posedge clk) begin
         if (load[c]) begin
            sreg   <= rec_target;
            cnt    <= '0;
            len_m1 <= rec_len - 1'b1;
         end else if (step && !last_r) begin
            sreg <= sreg >> 2;
            cnt  <= cnt + 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
         end else begin
            if (load[c]) wptr <= ptr_inc(wptr);
            if (pop)     rptr <= ptr_inc(rptr);
            case ({load[c], pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (load[c]) mem[wptr] <= rec_id;
      end

      assign bus.en[c]                             = (state == FEED);
      assign bus.last[c]                           = last_r;
      assign bus.data_out[2*c +: 2]                = (state == FEED) ? sreg[1:0] : 2'b00;
      assign bus.id_out[ID_WIDTH*c +: ID_WIDTH]    = mem[rptr];
      assign bus.id_empty[c]                       = (count == '0);
   end
endmodule

// File: tb/tb_sw_target_feeder_mc.sv
// Bench for sw_target_feeder_mc: queue-based channel/FIFO model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sw_target_feeder_mc;
   localparam int TL  = 128;
   localparam int LW  = 12;
   localparam int IW  = 48;
   localparam int CH  = 4;
   localparam int FD  = 4;
   localparam int INW = IW + LW + 2 * TL;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sw_target_feeder_mc_if #(.TARGET_LENGTH(TL), .LEN_WIDTH(LW), .ID_WIDTH(IW), .CHANNELS(CH)) ifc ();

`ifdef SW_FEEDER_STALL_EN
   logic [CH-1:0] stall = '0;
`endif

   sw_target_feeder_mc #(
      .TARGET_LENGTH(TL), .LEN_WIDTH(LW), .ID_WIDTH(IW), .CHANNELS(CH), .ID_FIFO_DEPTH(FD)
   ) dut (
      .clk(clk),
      .rst(rst),
`ifdef SW_FEEDER_STALL_EN
      .stall(stall),
`endif
      .bus(ifc)
   );

   int nvec = 0;
   int nerr = 0;
   int en0_run = 0, en0_max = 0, lerr_cnt = 0, en1_cnt = 0;
   bit last_acc;

   // Model: each channel holds the bases still to be shown; each FIFO holds its IDs.
   logic [1:0]    mq [CH][$];
   logic [IW-1:0] fq [CH][$];
   int            rr_m;
   bit            err_m;

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit m_avail(input int c);
      return (mq[c].size() <= 1) && (fq[c].size() < FD);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         mq[c].delete();
         fq[c].delete();
      end
      rr_m  = 0;
      err_m = 0;
   endtask

   task automatic check();
      logic [CH-1:0]   e_en, e_last, e_emp;
      logic [2*CH-1:0] e_d;
      bit              e_rdy;
      e_en = '0; e_last = '0; e_emp = '0; e_d = '0; e_rdy = 0;
      for (int c = 0; c < CH; c++) begin
         e_en[c]   = mq[c].size() > 0;
         e_last[c] = mq[c].size() == 1;
         e_emp[c]  = fq[c].size() == 0;
         if (mq[c].size() > 0) e_d[2*c +: 2] = mq[c][0];
         if (m_avail(c)) e_rdy = 1;
      end
      cmp("en", ifc.en, e_en);
      cmp("last", ifc.last, e_last);
      cmp("data_out", ifc.data_out, e_d);
      cmp("id_empty", ifc.id_empty, e_emp);
      cmp("in_ready", ifc.in_ready, e_rdy);
      cmp("len_err", ifc.len_err, err_m);
      for (int c = 0; c < CH; c++)
         if (fq[c].size() > 0) cmp($sformatf("id_out%0d", c), ifc.id_out[IW*c +: IW], fq[c][0]);
      if (ifc.en[0] === 1'b1) begin
         en0_run++;
         if (en0_run > en0_max) en0_max = en0_run;
      end else en0_run = 0;
      if (ifc.len_err === 1'b1) lerr_cnt++;
      if (ifc.en[1] === 1'b1) en1_cnt++;
   endtask

   task automatic model_step(input bit v, input logic [INW-1:0] d, input logic [CH-1:0] re);
      bit            av [CH];
      bit            rdy;
      int            len, sel;
      bit            found;
      rdy = 0;
      for (int c = 0; c < CH; c++) begin
         av[c] = m_avail(c);
         if (av[c]) rdy = 1;
      end
      for (int c = 0; c < CH; c++) begin
         if (re[c] && fq[c].size() > 0) void'(fq[c].pop_front());
         if (mq[c].size() > 0) void'(mq[c].pop_front());
      end
      err_m    = 0;
      last_acc = v && rdy;
      if (last_acc) begin
         len = int'(d[2*TL +: LW]);
         if (len == 0 || len > TL) err_m = 1;
         else begin
            found = 0;
            sel   = 0;
            for (int k = 0; k < CH; k++)
               if (!found && av[(rr_m + k) % CH]) begin
                  found = 1;
                  sel   = (rr_m + k) % CH;
               end
            mq[sel].delete();
            for (int i = 0; i < len; i++) mq[sel].push_back(d[2*i +: 2]);
            fq[sel].push_back(d[INW-1 -: IW]);
            rr_m = (sel + 1) % CH;
         end
      end
   endtask

   task automatic step(input bit v, input logic [INW-1:0] d, input logic [CH-1:0] re);
      check();
      ifc.in_valid = v;
      ifc.in_data  = d;
      ifc.id_re    = re;
      model_step(v, d, re);
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic [CH-1:0] re);
      for (int i = 0; i < n; i++) step(1'b0, '0, re);
   endtask

   task automatic send(input logic [INW-1:0] d, input logic [CH-1:0] re);
      int budget;
      budget = 0;
      do begin
         step(1'b1, d, re);
         budget++;
      end while (!last_acc && budget < 2000);
      ifc.in_valid = 1'b0;
      if (!last_acc) begin
         nvec++;
         nerr++;
         $display("FAIL send_timeout: record not accepted within %0d cycles", budget);
      end
   endtask

   task automatic do_reset();
      ifc.in_valid = 1'b0;
      ifc.id_re    = '0;
      rst          = 1'b0;
      @(negedge clk);
      model_reset();
      rst = 1'b1;
   endtask

   function automatic logic [INW-1:0] mk(input logic [IW-1:0] id, input int len,
                                          input logic [2*TL-1:0] tgt);
      return {id, LW'(len), tgt};
   endfunction

   function automatic logic [2*TL-1:0] rand_tgt();
      logic [2*TL-1:0] t;
      for (int w = 0; w < 2*TL/32; w++) t[32*w +: 32] = $urandom;
      return t;
   endfunction

   function automatic logic [INW-1:0] rand_rec();
      logic [63:0] idw;
      int          r, len;
      idw = {$urandom, $urandom};
      r   = $urandom_range(0, 15);
      case (r)
         0:       len = 0;
         1:       len = $urandom_range(129, 4095);
         2:       len = 128;
         3:       len = $urandom_range(20, 127);
         default: len = $urandom_range(1, 8);
      endcase
      return mk(idw[IW-1:0], len, rand_tgt());
   endfunction

   initial begin
      logic [2*TL-1:0] t1;
      ifc.in_valid = 1'b0;
      ifc.in_data  = '0;
      ifc.id_re    = '0;

      // Single short record on channel 0, then a length-1 record lands on channel 1.
      do_reset();
      cmp("t1_rdy_after_reset", ifc.in_ready, 1);
      cmp("t1_empty_after_reset", ifc.id_empty, 4'hF);
      t1 = '0;
      t1[5:0] = 6'b10_01_11;
      send(mk(48'hA5, 3, t1), '0);
      cmp("t1_en0_b0", ifc.en[0], 1);
      cmp("t1_b0", ifc.data_out[1:0], 2'd3);
      cmp("t1_id0", ifc.id_out[IW-1:0], 48'hA5);
      idle(1, '0);
      cmp("t1_b1", ifc.data_out[1:0], 2'd1);
      cmp("t1_last_b1", ifc.last[0], 0);
      idle(1, '0);
      cmp("t1_b2", ifc.data_out[1:0], 2'd2);
      cmp("t1_last_b2", ifc.last[0], 1);
      idle(1, '0);
      cmp("t1_en0_done", ifc.en[0], 0);
      send(mk(48'h5A, 1, rand_tgt()), '0);
      cmp("t1_rr_en", ifc.en, 4'b0010);
      cmp("t1_rr_last", ifc.last, 4'b0010);
      idle(2, '0);

      // Five full-length records: four channels fill, fifth reloads channel 0 seamlessly.
      do_reset();
      en0_max = 0;
      en0_run = 0;
      for (int i = 0; i < 5; i++) begin
         send(mk(48'(100 + i), 128, rand_tgt()), '0);
         if (i == 3) cmp("t2_ready_low", ifc.in_ready, 0);
      end
      idle(300, '0);
      cmp("t2_en0_run", en0_max, 256);

      // Bad lengths are consumed with len_err and leave the pointer alone.
      do_reset();
      lerr_cnt = 0;
      send(mk(48'h1, 0, rand_tgt()), '0);
      send(mk(48'h2, 129, rand_tgt()), '0);
      idle(3, '0);
      cmp("t3_len_err_cnt", lerr_cnt, 2);
      cmp("t3_empty", ifc.id_empty, 4'hF);
      cmp("t3_no_en", ifc.en, 4'b0000);
      send(mk(48'h3, 1, rand_tgt()), '0);
      cmp("t3_rr_unchanged", ifc.en, 4'b0001);
      idle(2, '0);

      // Channel 1 FIFO fills and is skipped; one pop makes room for exactly one more.
      do_reset();
      en1_cnt = 0;
      for (int i = 0; i < 24; i++) send(mk(48'(200 + i), 1, rand_tgt()), 4'b1101);
      idle(3, 4'b1101);
      cmp("t4_ch1_uses", en1_cnt, 4);
      cmp("t4_ch1_nonempty", ifc.id_empty[1], 0);
      idle(1, 4'b0010);
      for (int i = 0; i < 4; i++) send(mk(48'(300 + i), 1, rand_tgt()), 4'b1101);
      idle(3, 4'b1101);
      cmp("t4_ch1_reuse", en1_cnt, 5);

      // Reset while channel 2 is at base 10.
      do_reset();
      send(mk(48'h10, 1, rand_tgt()), '0);
      send(mk(48'h11, 1, rand_tgt()), '0);
      send(mk(48'h12, 20, rand_tgt()), '0);
      idle(10, '0);
      cmp("t5_ch2_busy", ifc.en[2], 1);
      rst          = 1'b0;
      ifc.in_valid = 1'b0;
      @(negedge clk);
      model_reset();
      rst = 1'b1;
      cmp("t5_en", ifc.en, 4'b0000);
      cmp("t5_last", ifc.last, 4'b0000);
      cmp("t5_data", ifc.data_out, 8'h00);
      cmp("t5_empty", ifc.id_empty, 4'hF);
      cmp("t5_ready", ifc.in_ready, 1);
      idle(2, '0);

      // Randomized traffic and pops.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic [CH-1:0] re;
         for (int c = 0; c < CH; c++) re[c] = ($urandom_range(0, 9) < 3);
         step($urandom_range(0, 1) == 1, rand_rec(), re);
      end
      idle(2, '0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/sw_target_feeder_mc.md
Name: sw_target_feeder_mc

Overview:
- N-channel target-sequence feeder for the Smith-Waterman scoring array.
- Accepts {ID, length, packed 2-bit target} records on a valid/ready interface.
- Assigns each record round-robin to a free channel and shifts the target out one base per cycle to that channel's scoring module.
- Queues the record's ID in a per-channel FIFO for the result collector.
- Generalises the two-slot toggle feeder: parametric channel count, real handshake, back-to-back reload, length checking.

Parameters:
TARGET_LENGTH, 128, max bases per target
LEN_WIDTH, 12, length field width
ID_WIDTH, 48, sequence ID width
CHANNELS, 4, number of scoring channels (>=1)
ID_FIFO_DEPTH, 4, per-channel ID FIFO depth (power of 2)
IN_WIDTH, ID_WIDTH+LEN_WIDTH+2*TARGET_LENGTH, record width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
in_data  in  IN_WIDTH  record, packed {ID[MSBs], LENGTH, TARGET[2*TARGET_LENGTH-1:0]}; base 0 = TARGET[1:0]
in_valid  in  1  record valid
in_ready  out  1  feeder can accept a record this cycle
en  out  CHANNELS  per-channel base-valid
last  out  CHANNELS  per-channel final-base marker
data_out  out  2*CHANNELS  per-channel base; channel c = [2c+1:2c]
id_re  in  CHANNELS  per-channel ID FIFO pop
id_out  out  ID_WIDTH*CHANNELS  per-channel FIFO head (first-word fall-through)
id_empty  out  CHANNELS  per-channel FIFO empty
len_err  out  1  one-cycle pulse on rejected record

Behaviour:
- Reset (rst=0 at clk edge): all channels IDLE; en, last, data_out, len_err = 0; FIFOs emptied; RR pointer = 0. Reset mid-feed aborts without output.
- Per-channel FSM:
  - IDLE -> FEED on accept.
  - FEED: shift register right by 2 each cycle; counter 0..len-1; en=1.
  - last=1 when counter==len-1.
  - FEED -> IDLE after the last base unless reloaded in that same cycle.
- Channel available if IDLE, or FEED with last=1, AND its ID FIFO not full.
- in_ready = OR of available over all channels (combinational from registered state). Accept = in_valid & in_ready.
- Assignment: first available channel scanning from RR pointer upward, with wrap. Pointer <- assigned+1 mod CHANNELS on accept.
- Latency: accept at edge k; base 0 appears with en=1 in cycle k+1. Bases 1..len-1 follow in consecutive cycles, no bubbles.
- Back-to-back reload: if a channel is reloaded on its last-base cycle, en stays high and the new base 0 follows immediately.
- ID push happens on the accept edge to the assigned channel's FIFO.
- Pop: id_re on an empty FIFO is ignored. Simultaneous push and pop on a full FIFO is not possible, because a full FIFO makes its channel unavailable.
- Length rules:
  - LENGTH==0 or LENGTH>TARGET_LENGTH: record is consumed (in_ready honoured), no channel assigned, no ID pushed, RR pointer unchanged, len_err pulses in the next cycle.
  - LENGTH==1: a single cycle with en=1 and last=1.
- When en=0, data_out for that channel = 2'b00.
- Counters are LEN_WIDTH wide; they never wrap, because length is bounded by TARGET_LENGTH.

Optional Feature:
- Macro SW_FEEDER_STALL_EN.
- Defined:
  - Extra input port stall [CHANNELS].
  - While stall[c]=1, channel c holds its shift register, counter, en, last and data_out.
  - A stalled channel on its last base is not available for reload.
  - Reset overrides stall.
- Undefined: no stall port; channels never pause.

Test Plan:
- Reset then single record (ID=0xA5, LENGTH=3, TARGET[5:0]=6'b10_01_11), CHANNELS=4 -> channel 0 en=1 for 3 cycles starting 1 cycle after accept; data_out[1:0]=3,1,2; last on 3rd; id_out[0]=0xA5; RR pointer=1.
- Five records of LENGTH=128 back-to-back -> channels 0,1,2,3 assigned, in_ready=0 from cycle 4; fifth accepted on channel 0's last-base cycle; channel 0 en continuous for 256 cycles.
- LENGTH=0 then LENGTH=129 -> both consumed, len_err pulses twice, no en activity, id_empty all 1, pointer unchanged.
- Fill channel 1's FIFO (4 IDs, no pops) -> channel 1 skipped by assignment once idle; pop one -> channel 1 reusable.
- Assert rst=0 mid-feed on channel 2 at base 10 -> next cycle en=0, last=0, data_out=0, id_empty=all 1, in_ready=1.
- (SW_FEEDER_STALL_EN) stall[0]=1 for 5 cycles at base 2 of LENGTH=4 -> base 2 held for 6 cycles, then bases 2..3 resume; total en-high cycles = 9.
